// File: rtl/vert_ucode_quicksort_pkg.sv
// Shared types for the quicksort bank scheduler: bank ids, entry counts,
// per-bank lifecycle status and the legal-successor helper.
package vert_ucode_quicksort_pkg;

   localparam int BANK_N = 2;
   localparam int N      = 16;
   localparam int BANK_W = (BANK_N > 1) ? $clog2(BANK_N) : 1;
   localparam int N_W    = $clog2(N + 1);

   typedef logic [BANK_W-1:0] bank_n_t;
   typedef bank_n_t           sched_ptr_t;
   typedef logic [BANK_N-1:0] bank_n_d_t;
   typedef logic [N_W-1:0]    n_t;

   typedef enum logic [2:0] {
      BANK_IDLE      = 3'd0,
      BANK_LOADING   = 3'd1,
      BANK_READY     = 3'd2,
      BANK_SORTING   = 3'd3,
      BANK_SORTED    = 3'd4,
      BANK_UNLOADING = 3'd5
   } bank_status_t;

   typedef struct packed {
      bank_status_t status;
      n_t           n;
      logic         error;
   } bank_state_t;

   function automatic bank_status_t bank_advance(input bank_status_t s);
      case (s)
         BANK_IDLE:      return BANK_LOADING;
         BANK_LOADING:   return BANK_READY;
         BANK_READY:     return BANK_SORTING;
         BANK_SORTING:   return BANK_SORTED;
         BANK_SORTED:    return BANK_UNLOADING;
         default:        return BANK_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/vert_ucode_quicksort_sched_bank.sv
// One sort bank's lifecycle state {status, n, error}, stepped by strobes.
// VERT_UCODE_QUICKSORT_SCHED_EMPTY_SKIP_EN: loads of 0/1 entries bypass sorting.
module vert_ucode_quicksort_sched_bank
   import vert_ucode_quicksort_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        load_done,
   input  n_t          load_n,
   input  logic        start,
   input  logic        skip_clr,
   input  logic        sort_done,
   input  logic        sort_err,
   input  logic        unload,
   input  logic        unload_done,
   output bank_state_t state,
   output logic        skip_pend
);

   bank_status_t status_reg, status_next;
   n_t           n_reg, n_next;
   logic         error_reg, error_next;
   logic         skip_reg, skip_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         status_reg <= BANK_IDLE;
         n_reg      <= '0;
         error_reg  <= 1'b0;
         skip_reg   <= 1'b0;
      end else begin
         status_reg <= status_next;
         n_reg      <= n_next;
         error_reg  <= error_next;
         skip_reg   <= skip_next;
      end
   end

   // Done strobes are broadcast; only a bank in the matching state reacts.
   always_comb begin
      status_next = status_reg;
      n_next      = n_reg;
      error_next  = error_reg;
      skip_next   = skip_reg && !skip_clr;
      case (status_reg)
         BANK_IDLE:    if (load) status_next = bank_advance(status_reg);
         BANK_LOADING: if (load_done) begin
            n_next      = load_n;
            status_next = bank_advance(status_reg);
`ifdef VERT_UCODE_QUICKSORT_SCHED_EMPTY_SKIP_EN
            // Nothing to sort: mark so the sort pointer steps over this bank.
            if (load_n <= n_t'(1)) begin
               status_next = BANK_SORTED;
               error_next  = 1'b0;
               skip_next   = 1'b1;
            end
`endif
         end
         BANK_READY:   if (start) status_next = bank_advance(status_reg);
         BANK_SORTING: if (sort_done) begin
            status_next = bank_advance(status_reg);
            error_next  = sort_err;
         end
         BANK_SORTED:  if (unload) status_next = bank_advance(status_reg);
         BANK_UNLOADING: if (unload_done) begin
            status_next = BANK_IDLE;
            n_next      = '0;
            error_next  = 1'b0;
            skip_next   = 1'b0;
         end
         default:      status_next = BANK_IDLE;
      endcase
   end

   assign state     = '{status: status_reg, n: n_reg, error: error_reg};
   assign skip_pend = skip_reg;

endmodule

// File: rtl/vert_ucode_quicksort_bank_sched.sv
// Bank scheduler: hands banks to load, sort and unload clients in strict
// round-robin order, with at most one bank in each in-progress state.
module vert_ucode_quicksort_bank_sched
   import vert_ucode_quicksort_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enq_req,
   output logic                     enq_gnt,
   output bank_n_t                  enq_bank,
   input  logic                     enq_done,
   input  n_t                       enq_n,
   output logic                     sort_vld,
   output bank_n_t                  sort_bank,
   output n_t                       sort_n,
   input  logic                     sort_ack,
   input  logic                     sort_done,
   input  logic                     sort_error,
   output logic                     deq_vld,
   output bank_n_t                  deq_bank,
   output n_t                       deq_n,
   output logic                     deq_error,
   input  logic                     deq_ack,
   input  logic                     deq_done,
   output bank_state_t [BANK_N-1:0] bank_state,
   output logic                     proto_err,
   output logic                     busy
);

   sched_ptr_t enq_ptr_reg, sort_ptr_reg, deq_ptr_reg;
   logic       proto_err_reg, proto_err_next;
   bank_n_d_t  idle_d, loading_d, ready_d, sorting_d, sorted_d, unloading_d, skip_d;
   logic       sort_fire, deq_fire, skip_fire;

   for (genvar gi = 0; gi < BANK_N; gi++) begin : g_bank
      assign idle_d[gi]      = bank_state[gi].status == BANK_IDLE;
      assign loading_d[gi]   = bank_state[gi].status == BANK_LOADING;
      assign ready_d[gi]     = bank_state[gi].status == BANK_READY;
      assign sorting_d[gi]   = bank_state[gi].status == BANK_SORTING;
      assign sorted_d[gi]    = bank_state[gi].status == BANK_SORTED;
      assign unloading_d[gi] = bank_state[gi].status == BANK_UNLOADING;

      vert_ucode_quicksort_sched_bank u_bank (
         .clk         (clk),
         .rst_n       (rst_n),
         .load        (enq_gnt && enq_ptr_reg == bank_n_t'(gi)),
         .load_done   (enq_done),
         .load_n      (enq_n),
         .start       (sort_fire && sort_ptr_reg == bank_n_t'(gi)),
         .skip_clr    (skip_fire && sort_ptr_reg == bank_n_t'(gi)),
         .sort_done   (sort_done),
         .sort_err    (sort_error),
         .unload      (deq_fire && deq_ptr_reg == bank_n_t'(gi)),
         .unload_done (deq_done),
         .state       (bank_state[gi]),
         .skip_pend   (skip_d[gi])
      );
   end

   assign enq_gnt   = enq_req && idle_d[enq_ptr_reg] && !(|loading_d);
   assign sort_vld  = ready_d[sort_ptr_reg] && !(|sorting_d);
   assign deq_vld   = sorted_d[deq_ptr_reg] && !(|unloading_d);
   assign sort_fire = sort_vld && sort_ack;
   assign deq_fire  = deq_vld && deq_ack;
   // A skipped bank is never offered; the sort pointer just walks past it.
   assign skip_fire = skip_d[sort_ptr_reg];

   assign enq_bank  = enq_ptr_reg;
   assign sort_bank = sort_ptr_reg;
   assign sort_n    = bank_state[sort_ptr_reg].n;
   assign deq_bank  = deq_ptr_reg;
   assign deq_n     = bank_state[deq_ptr_reg].n;
   assign deq_error = bank_state[deq_ptr_reg].error;
   assign busy      = !(&idle_d);
   assign proto_err = proto_err_reg;

   assign proto_err_next = proto_err_reg
                         | (enq_done  && !(|loading_d))
                         | (sort_done && !(|sorting_d))
                         | (deq_done  && !(|unloading_d));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         enq_ptr_reg   <= '0;
         sort_ptr_reg  <= '0;
         deq_ptr_reg   <= '0;
         proto_err_reg <= 1'b0;
      end else begin
         if (enq_gnt)               enq_ptr_reg  <= enq_ptr_reg + sched_ptr_t'(1);
         if (sort_fire || skip_fire) sort_ptr_reg <= sort_ptr_reg + sched_ptr_t'(1);
         if (deq_fire)              deq_ptr_reg  <= deq_ptr_reg + sched_ptr_t'(1);
         proto_err_reg <= proto_err_next;
      end
   end

endmodule

// File: tb/tb_vert_ucode_quicksort_bank_sched.sv
// Scoreboard bench for the bank scheduler: stimulus queues expected handshakes,
// a negedge monitor pops and compares them; state checks are directed.
module tb_vert_ucode_quicksort_bank_sched;
   import vert_ucode_quicksort_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enq_req = 1'b0, enq_gnt, enq_done = 1'b0;
   bank_n_t enq_bank, sort_bank, deq_bank;
   n_t enq_n = '0, sort_n, deq_n;
   logic sort_vld, sort_ack = 1'b0, sort_done = 1'b0, sort_error = 1'b0;
   logic deq_vld, deq_error, deq_ack = 1'b0, deq_done = 1'b0;
   bank_state_t [BANK_N-1:0] bank_state;
   logic proto_err, busy;

   always #5 clk = ~clk;

   vert_ucode_quicksort_bank_sched dut (
      .clk(clk), .rst_n(rst_n),
      .enq_req(enq_req), .enq_gnt(enq_gnt), .enq_bank(enq_bank),
      .enq_done(enq_done), .enq_n(enq_n),
      .sort_vld(sort_vld), .sort_bank(sort_bank), .sort_n(sort_n),
      .sort_ack(sort_ack), .sort_done(sort_done), .sort_error(sort_error),
      .deq_vld(deq_vld), .deq_bank(deq_bank), .deq_n(deq_n),
      .deq_error(deq_error), .deq_ack(deq_ack), .deq_done(deq_done),
      .bank_state(bank_state), .proto_err(proto_err), .busy(busy)
   );

   typedef struct {int bank; int n; int err;} exp_t;
   int   enq_q[$];
   exp_t sort_q[$];
   exp_t deq_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   mon_b;
   exp_t mon_e;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int st(input int b);
      return int'(bank_state[b].status);
   endfunction

   // Monitor: every accepted handshake is checked against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (enq_req && enq_gnt) begin
            if (enq_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("[TB] FAIL enq_unexpected: grant bank %0d, none expected", enq_bank);
            end else begin
               mon_b = enq_q.pop_front();
               $display("[TB] enq grant bank=%0d", enq_bank);
               chk("enq_bank", int'(enq_bank), mon_b);
            end
         end
         if (sort_vld && sort_ack) begin
            if (sort_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("[TB] FAIL sort_unexpected: offer bank %0d, none expected", sort_bank);
            end else begin
               mon_e = sort_q.pop_front();
               $display("[TB] sort accept bank=%0d n=%0d", sort_bank, sort_n);
               chk("sort_bank", int'(sort_bank), mon_e.bank);
               chk("sort_n", int'(sort_n), mon_e.n);
            end
         end
         if (deq_vld && deq_ack) begin
            if (deq_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("[TB] FAIL deq_unexpected: offer bank %0d, none expected", deq_bank);
            end else begin
               mon_e = deq_q.pop_front();
               $display("[TB] deq accept bank=%0d n=%0d err=%0d", deq_bank, deq_n, deq_error);
               chk("deq_bank", int'(deq_bank), mon_e.bank);
               chk("deq_n", int'(deq_n), mon_e.n);
               chk("deq_error", int'(deq_error), mon_e.err);
            end
         end
      end
   end

   task automatic grant_bank(input int b);
      enq_req = 1'b1;
      enq_q.push_back(b);
      @(negedge clk);
      chk("grant", int'(enq_gnt), 1);
      cyc();
      enq_req = 1'b0;
   endtask

   // Drives a LOADING bank through the rest of its lifecycle back to IDLE.
   task automatic finish_bank(input int b, input int n, input int err);
      enq_done = 1'b1; enq_n = n_t'(n);
      @(negedge clk); chk("st_loading", st(b), int'(BANK_LOADING));
      cyc(); enq_done = 1'b0;
      sort_ack = 1'b1; sort_q.push_back('{b, n, 0});
      @(negedge clk); chk("st_ready", st(b), int'(BANK_READY));
      chk("sort_vld", int'(sort_vld), 1);
      cyc(); sort_ack = 1'b0;
      sort_done = 1'b1; sort_error = err[0];
      @(negedge clk); chk("st_sorting", st(b), int'(BANK_SORTING));
      cyc(); sort_done = 1'b0; sort_error = 1'b0;
      deq_ack = 1'b1; deq_q.push_back('{b, n, err});
      @(negedge clk); chk("st_sorted", st(b), int'(BANK_SORTED));
      chk("st_error", int'(bank_state[b].error), err);
      cyc(); deq_ack = 1'b0;
      deq_done = 1'b1;
      @(negedge clk); chk("st_unloading", st(b), int'(BANK_UNLOADING));
      cyc(); deq_done = 1'b0;
      @(negedge clk); chk("st_idle", st(b), int'(BANK_IDLE));
      chk("idle_n", int'(bank_state[b].n), 0);
      cyc();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      cyc(); cyc();
      @(negedge clk);
      chk("rst_enq_gnt", int'(enq_gnt), 0);
      chk("rst_enq_bank", int'(enq_bank), 0);
      chk("rst_sort_vld", int'(sort_vld), 0);
      chk("rst_sort_n", int'(sort_n), 0);
      chk("rst_deq_vld", int'(deq_vld), 0);
      chk("rst_deq_n", int'(deq_n), 0);
      chk("rst_deq_error", int'(deq_error), 0);
      chk("rst_proto_err", int'(proto_err), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_bank_state", int'(bank_state), 0);
      cyc();
      rst_n = 1'b1;

      // Zero-latency grant, then a second request while loading is refused
      enq_req = 1'b1;
      enq_q.push_back(0);
      @(negedge clk); chk("t1_gnt", int'(enq_gnt), 1);
      cyc();
      @(negedge clk);
      chk("t1_second_gnt", int'(enq_gnt), 0);
      chk("t1_loading", st(0), int'(BANK_LOADING));
      cyc(); enq_req = 1'b0;
      finish_bank(0, 16, 0);
      @(negedge clk); chk("t2_busy0", int'(busy), 0);
      cyc();
      grant_bank(1);
      finish_bank(1, 16, 0);
      @(negedge clk); chk("t2_busy1", int'(busy), 0);
      cyc();

      // Overlap, full, and free-then-grant one cycle later
      grant_bank(0);
      enq_done = 1'b1; enq_n = n_t'(5);
      cyc(); enq_done = 1'b0;
      sort_ack = 1'b1; sort_q.push_back('{0, 5, 0});
      enq_req = 1'b1; enq_q.push_back(1);
      @(negedge clk); chk("t3_gnt1", int'(enq_gnt), 1);
      cyc(); sort_ack = 1'b0;
      @(negedge clk);
      chk("t3_full_gnt", int'(enq_gnt), 0);
      chk("t3_busy", int'(busy), 1);
      chk("t3_st0", st(0), int'(BANK_SORTING));
      chk("t3_st1", st(1), int'(BANK_LOADING));
      cyc();
      enq_done = 1'b1; enq_n = n_t'(7); sort_done = 1'b1; sort_error = 1'b0;
      cyc(); enq_done = 1'b0; sort_done = 1'b0;
      sort_ack = 1'b1; sort_q.push_back('{1, 7, 0});
      deq_ack = 1'b1;  deq_q.push_back('{0, 5, 0});
      @(negedge clk); chk("t3_full_gnt2", int'(enq_gnt), 0);
      cyc(); sort_ack = 1'b0; deq_ack = 1'b0;
      sort_done = 1'b1; sort_error = 1'b1; deq_done = 1'b1;
      @(negedge clk); chk("t3_same_cycle_gnt", int'(enq_gnt), 0);
      cyc(); sort_done = 1'b0; sort_error = 1'b0; deq_done = 1'b0;
      enq_q.push_back(0);
      deq_ack = 1'b1; deq_q.push_back('{1, 7, 1});
      @(negedge clk);
      chk("t3_regrant", int'(enq_gnt), 1);
      chk("t4_err_stored", int'(bank_state[1].error), 1);
      cyc(); enq_req = 1'b0; deq_ack = 1'b0;
      deq_done = 1'b1;
      cyc(); deq_done = 1'b0;
      @(negedge clk);
      chk("t4_st1_idle", st(1), int'(BANK_IDLE));
      chk("t4_err_cleared", int'(bank_state[1].error), 0);
      cyc();
      finish_bank(0, 3, 0);
      @(negedge clk); chk("t4_proto_ok", int'(proto_err), 0);
      cyc();

      // Stray done pulse: ignored, sticky proto_err until reset
      deq_done = 1'b1;
      cyc(); deq_done = 1'b0;
      @(negedge clk);
      chk("t5_proto_set", int'(proto_err), 1);
      chk("t5_state_same", int'(bank_state), 0);
      chk("t5_busy", int'(busy), 0);
      cyc(); cyc(); cyc();
      @(negedge clk); chk("t5_proto_sticky", int'(proto_err), 1);
      cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      @(negedge clk); chk("t5_proto_cleared", int'(proto_err), 0);
      cyc();

      // Empty load (n=0)
      grant_bank(0);
      enq_done = 1'b1; enq_n = n_t'(0);
      cyc(); enq_done = 1'b0;
`ifdef VERT_UCODE_QUICKSORT_SCHED_EMPTY_SKIP_EN
      deq_ack = 1'b1; deq_q.push_back('{0, 0, 0});
      @(negedge clk);
      chk("t6_st_sorted", st(0), int'(BANK_SORTED));
      chk("t6_sort_vld", int'(sort_vld), 0);
      chk("t6_deq_vld", int'(deq_vld), 1);
      cyc(); deq_ack = 1'b0;
      deq_done = 1'b1;
      @(negedge clk); chk("t6_sort_vld2", int'(sort_vld), 0);
      cyc(); deq_done = 1'b0;
`else
      sort_ack = 1'b1; sort_q.push_back('{0, 0, 0});
      @(negedge clk);
      chk("t6_st_ready", st(0), int'(BANK_READY));
      chk("t6_sort_vld", int'(sort_vld), 1);
      cyc(); sort_ack = 1'b0;
      sort_done = 1'b1;
      cyc(); sort_done = 1'b0;
      deq_ack = 1'b1; deq_q.push_back('{0, 0, 0});
      cyc(); deq_ack = 1'b0;
      deq_done = 1'b1;
      cyc(); deq_done = 1'b0;
`endif
      // Ordering continues with bank 1 regardless of the skip
      grant_bank(1);
      finish_bank(1, 9, 0);

      @(negedge clk);
      chk("end_busy", int'(busy), 0);
      chk("end_enq_q", enq_q.size(), 0);
      chk("end_sort_q", sort_q.size(), 0);
      chk("end_deq_q", deq_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vert_ucode_quicksort_bank_sched.md
Name: vert_ucode_quicksort_bank_sched

Overview:
Bank scheduler for the vertical-microcode quicksort. It owns the per-bank lifecycle state for BANK_N sort banks and hands banks out in strict allocation order to three clients: the enqueue FSM (load), the microcode sort engine (sort) and the dequeue FSM (unload). Loads, sorts and unloads of different banks overlap. At most one bank is in each of LOADING, SORTING and UNLOADING at any time.

Parameters:
BANK_N, 2, number of banks (package constant; must be a power of 2, at least 2)
N, 16, maximum entries per bank (package constant; sets n_t width)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
enq_req  in  1  enqueue FSM requests a bank to load
enq_gnt  out  1  bank granted this cycle
enq_bank  out  bank_n_t  granted bank id; valid when enq_gnt
enq_done  in  1  load complete (single-cycle pulse)
enq_n  in  n_t  entry count loaded; valid with enq_done
sort_vld  out  1  a READY bank is offered to the sort engine
sort_bank  out  bank_n_t  offered bank id
sort_n  out  n_t  entry count of offered bank
sort_ack  in  1  sort engine accepts the offer
sort_done  in  1  sort complete (pulse)
sort_error  in  1  sort engine error; valid with sort_done
deq_vld  out  1  a SORTED bank is offered to dequeue
deq_bank  out  bank_n_t  offered bank id
deq_n  out  n_t  entry count
deq_error  out  1  stored error flag of offered bank
deq_ack  in  1  dequeue accepts the offer
deq_done  in  1  unload complete (pulse)
bank_state  out  BANK_N x bank_state_t  per-bank {status, n, error}
proto_err  out  1  sticky: done pulse with no matching bank in progress
busy  out  1  any bank not IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): every bank is {BANK_IDLE, n=0, error=0}; enq_ptr, sort_ptr and deq_ptr are 0; proto_err is 0. All outputs are 0 in the cycle after reset. Reset applied mid-operation aborts all banks with no completion handshake.
- Per-bank FSM: IDLE -> LOADING -> READY -> SORTING -> SORTED -> UNLOADING -> IDLE. No other transitions are legal.
- Ordering: each of the three pointers advances modulo BANK_N when its transition fires, so banks are loaded, sorted and unloaded in the same order.
- Enqueue: enq_gnt = enq_req and bank[enq_ptr] is IDLE and no bank is LOADING. This is combinational, with zero-cycle latency. On grant, the bank becomes LOADING at the next edge and enq_ptr advances.
- enq_done moves the LOADING bank to READY and captures enq_n into n. A grant and an enq_done in the same cycle are legal and target different banks.
- Sort: sort_vld = bank[sort_ptr] is READY and no bank is SORTING. sort_bank and sort_n are stable while sort_vld && !sort_ack. On sort_vld && sort_ack the bank becomes SORTING and sort_ptr advances.
- sort_done moves the SORTING bank to SORTED and captures error = sort_error.
- Dequeue: deq_vld = bank[deq_ptr] is SORTED and no bank is UNLOADING. On deq_vld && deq_ack the bank becomes UNLOADING and deq_ptr advances. deq_done returns it to IDLE with n and error cleared.
- Back-to-back: a bank freed by deq_done is grantable to enq_req in the following cycle, not the same cycle. Same rule for READY -> offer and SORTED -> offer: each is visible one cycle after the transition.
- A done pulse arriving while no bank is in the matching state is ignored and sets proto_err. proto_err clears only on reset.
- Full condition: all banks non-IDLE, so enq_gnt=0. Empty condition: all IDLE, so busy=0 and no offers are made.
- enq_n is taken as-is; values above N are not checked.

Optional Feature:
VERT_UCODE_QUICKSORT_SCHED_EMPTY_SKIP_EN
- Defined: an enq_done with enq_n <= 1 moves the bank directly LOADING -> SORTED with error=0. sort_ptr advances past it at the point it would have been offered, so ordering is preserved (skip occurs when sort_ptr reaches it with sort_vld masked).
- Undefined: every bank passes through sort regardless of n.

Decomposition:
- Package vert_ucode_quicksort_pkg gets:
  - sched_ptr_t (alias of bank_n_t)
  - a helper function bank_advance(bank_status_t) returning the legal successor state
  - SCHED_NO_BANK-free one-hot bank_n_d_t usage for "state == X" vectors
- Sub-module vert_ucode_quicksort_sched_bank holds one bank's status, n and error, and takes load/start/done strobes. It is instantiated BANK_N times.
- Top level holds the three pointers, the offer/grant logic and proto_err.

Test Plan:
1. Reset, then enq_req=1 -> enq_gnt=1, enq_bank=0 in the same cycle; bank0 LOADING next cycle. A second enq_req while bank0 is LOADING -> enq_gnt=0.
2. Full pipeline on bank0, then bank1: enq_done with enq_n=16, sort_ack, sort_done with sort_error=0, deq_ack, deq_done -> bank states step through all six in order; deq_n=16, deq_error=0; busy returns to 0.
3. Overlap: bank0 SORTING while bank1 LOADING, plus a third enq_req -> enq_gnt=0 (full). After bank0 deq_done -> enq_bank=0 granted one cycle later.
4. sort_done with sort_error=1 on bank1 -> deq_vld with deq_bank=1, deq_error=1; after deq_done, bank1 error=0.
5. deq_done pulse with no UNLOADING bank -> state unchanged, proto_err=1 and stays 1 until rst_n=0.
6. EMPTY_SKIP_EN defined: enq_done with enq_n=0 -> bank goes straight to SORTED, sort_vld never asserted for it, deq_vld next cycle with deq_n=0. With the macro undefined the same stimulus produces sort_vld=1.
